// File: rtl/thread_disp_resp_pkg.sv
// Shared message codes, bus widths, FSM encodings and table types for the thread dispatcher responder.
package thread_disp_resp_pkg;

    localparam int CPU_MSG_SIZE = 4;
    localparam int ADDR_SIZE    = 32;
    localparam int DATA_SIZE    = 32;

    localparam logic [DATA_SIZE-1:0] THRD_ID_NONE = 32'hFFFF_FFFF;

    typedef enum logic [CPU_MSG_SIZE-1:0] {
        CPU_R_IDLE      = 4'h0,
        CPU_R_FORK_THRD = 4'h1,
        CPU_R_STOP_THRD = 4'h2,
        CPU_R_FORK_DONE = 4'h3,
        CPU_R_STOP_DONE = 4'h4
    } cpu_msg_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REPLY  = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic                 is_stop;
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] data;
    } disp_req_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] base;
        logic [DATA_SIZE-1:0] entry;
        logic [DATA_SIZE-1:0] exitw;
    } thrd_slot_t;

    function automatic logic is_req_code(input logic [CPU_MSG_SIZE-1:0] code);
        return (code == CPU_R_FORK_THRD) || (code == CPU_R_STOP_THRD);
    endfunction

endpackage

// File: rtl/thread_disp_resp_slot_enc.sv
// Combinational slot encoder: lowest free slot and the valid slot whose base matches the request.
module thrd_slot_enc
    import thread_disp_resp_pkg::*;
#(
    parameter int THREADS = 8,
    parameter int SLOT_W  = 3
) (
    input  logic [THREADS-1:0]                i_valid,
    input  logic [THREADS-1:0][ADDR_SIZE-1:0] i_base,
    input  logic [ADDR_SIZE-1:0]              i_addr,
    output logic                              o_hit,
    output logic [SLOT_W-1:0]                 o_hit_idx,
    output logic                              o_free,
    output logic [SLOT_W-1:0]                 o_free_idx
);

    logic [THREADS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < THREADS; gi++) begin : g_match
            assign w_match[gi] = i_valid[gi] && (i_base[gi] == i_addr);
        end
    endgenerate

    // Scan from the top down so the lowest index is the last one written.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        o_free     = 1'b0;
        o_free_idx = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit     = 1'b1;
                o_hit_idx = SLOT_W'(i);
            end
            if (!i_valid[i]) begin
                o_free     = 1'b1;
                o_free_idx = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/thread_disp_resp.sv
// Dispatcher-side responder: services fork/stop requests against a thread slot table.
// Optional THRD_DISP_STATS_EN adds active_cnt and fail_cnt outputs.
module thread_disp_resp
    import thread_disp_resp_pkg::*;
#(
    parameter int                   THREADS = 8,
    parameter int                   SLOT_W  = $clog2(THREADS),
    parameter logic [DATA_SIZE-1:0] ID_NONE = THRD_ID_NONE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_oe,
    input  logic                    cpu_msg_pulse,
    input  logic [CPU_MSG_SIZE-1:0] cpu_msg_in,
    input  logic [ADDR_SIZE-1:0]    addr_in,
    input  logic [DATA_SIZE-1:0]    data_in,
    output logic [CPU_MSG_SIZE-1:0] cpu_msg_out,
    output logic [DATA_SIZE-1:0]    data_out,
    output logic                    disp_online,
    output logic [THREADS-1:0]      active_mask
`ifdef THRD_DISP_STATS_EN
    ,
    output logic [SLOT_W:0]         active_cnt,
    output logic [15:0]             fail_cnt
`endif
);

    disp_state_e                       r_state, w_state_nxt;
    disp_req_t                         r_req;
    logic [THREADS-1:0]                r_valid, w_valid_nxt;
    thrd_slot_t                        r_tab [THREADS];
    logic [THREADS-1:0][ADDR_SIZE-1:0] w_bases;
    logic                              w_hit, w_free;
    logic [SLOT_W-1:0]                 w_hit_idx, w_free_idx;
    logic                              w_take, w_commit, w_alloc, w_release;
    logic [DATA_SIZE-1:0]              w_result;
    logic [CPU_MSG_SIZE-1:0]           r_msg_out;
    logic [DATA_SIZE-1:0]              r_data_out;
    logic                              r_online;

    always_comb begin
        for (int i = 0; i < THREADS; i++) w_bases[i] = r_tab[i].base;
    end

    thrd_slot_enc #(.THREADS(THREADS), .SLOT_W(SLOT_W)) u_enc (
        .i_valid    (r_valid),
        .i_base     (w_bases),
        .i_addr     (r_req.addr),
        .o_hit      (w_hit),
        .o_hit_idx  (w_hit_idx),
        .o_free     (w_free),
        .o_free_idx (w_free_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_msg_pulse && is_req_code(cpu_msg_in)) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_REPLY;
            end
            ST_REPLY: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A fork whose base already lives in the table is rejected even if a slot is free.
    always_comb begin
        w_result  = ID_NONE;
        w_alloc   = 1'b0;
        w_release = 1'b0;
        if (r_req.is_stop) begin
            if (w_hit) begin
                w_result  = DATA_SIZE'(w_hit_idx);
                w_release = 1'b1;
            end
        end else if (!w_hit && w_free) begin
            w_result = DATA_SIZE'(w_free_idx);
            w_alloc  = 1'b1;
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_commit && w_alloc)   w_valid_nxt[w_free_idx] = 1'b1;
        if (w_commit && w_release) w_valid_nxt[w_hit_idx]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_valid    <= '0;
            r_msg_out  <= '0;
            r_data_out <= '0;
            r_online   <= 1'b0;
            for (int i = 0; i < THREADS; i++) r_tab[i] <= '0;
        end else if (clk_oe) begin
            r_state  <= w_state_nxt;
            r_online <= (w_state_nxt == ST_IDLE);
            r_valid  <= w_valid_nxt;
            if (w_take) begin
                r_req.is_stop <= (cpu_msg_in == CPU_R_STOP_THRD);
                r_req.addr    <= addr_in;
                r_req.data    <= data_in;
            end
            if (w_commit && w_alloc) begin
                r_tab[w_free_idx].base  <= r_req.addr;
                r_tab[w_free_idx].entry <= r_req.data;
            end
            if (w_commit && w_release) r_tab[w_hit_idx].exitw <= r_req.data;
            // Reply registers load on the LOOKUP edge and clear on the next enabled edge.
            if (w_commit) begin
                r_msg_out  <= r_req.is_stop ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
                r_data_out <= w_result;
            end else begin
                r_msg_out  <= '0;
                r_data_out <= '0;
            end
        end
    end

    assign cpu_msg_out = r_msg_out;
    assign data_out    = r_data_out;
    assign disp_online = r_online;
    assign active_mask = r_valid;

`ifdef THRD_DISP_STATS_EN
    logic [SLOT_W:0] r_active_cnt, w_cnt_nxt;
    logic [15:0]     r_fail_cnt;

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < THREADS; i++) w_cnt_nxt = w_cnt_nxt + (SLOT_W+1)'(w_valid_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active_cnt <= '0;
            r_fail_cnt   <= '0;
        end else if (clk_oe) begin
            r_active_cnt <= w_cnt_nxt;
            if (w_commit && !(w_alloc || w_release) && (r_fail_cnt != 16'hFFFF))
                r_fail_cnt <= r_fail_cnt + 16'd1;
        end
    end

    assign active_cnt = r_active_cnt;
    assign fail_cnt   = r_fail_cnt;
`endif

endmodule

// File: tb/tb_thread_disp_resp.sv
// Scoreboard bench for thread_disp_resp: expected replies queued at request time, checked on reply.
module tb_thread_disp_resp;
    import thread_disp_resp_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, clk_oe = 1'b1, cpu_msg_pulse = 1'b0;
    logic [3:0]  cpu_msg_in = 4'h0;
    logic [31:0] addr_in = '0, data_in = '0;
    logic [3:0]  cpu_msg_out;
    logic [31:0] data_out;
    logic        disp_online;
    logic [7:0]  active_mask;
`ifdef THRD_DISP_STATS_EN
    logic [3:0]  active_cnt;
    logic [15:0] fail_cnt;
`endif

    thread_disp_resp dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .cpu_msg_pulse(cpu_msg_pulse),
        .cpu_msg_in(cpu_msg_in), .addr_in(addr_in), .data_in(data_in),
        .cpu_msg_out(cpu_msg_out), .data_out(data_out),
        .disp_online(disp_online), .active_mask(active_mask)
`ifdef THRD_DISP_STATS_EN
        , .active_cnt(active_cnt), .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  msg;
        logic [31:0] data;
        logic [7:0]  mask;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  m_valid = '0;
    logic [31:0] m_base [8];
    int          m_fail = 0;

    task automatic predict(input logic is_stop, input logic [31:0] addr, output logic [31:0] res);
        int hit, fr;
        hit = -1;
        fr  = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_valid[i] && m_base[i] == addr) hit = i;
            if (!m_valid[i]) fr = i;
        end
        res = 32'hFFFF_FFFF;
        if (is_stop) begin
            if (hit >= 0) begin
                res = 32'(hit);
                m_valid[hit] = 1'b0;
            end
        end else if (hit < 0 && fr >= 0) begin
            res = 32'(fr);
            m_valid[fr] = 1'b1;
            m_base[fr]  = addr;
        end
        if (res == 32'hFFFF_FFFF) m_fail++;
    endtask

    always @(negedge clk) begin
        if (rst && cpu_msg_out != 4'h0) begin
            exp_t e;
            if (sb.size() == 0) chk("unexpected_reply", 32'(cpu_msg_out), 32'h0);
            else begin
                e = sb.pop_front();
                chk("reply_msg",   32'(cpu_msg_out), 32'(e.msg));
                chk("reply_data",  data_out, e.data);
                chk("reply_mask",  32'(active_mask), 32'(e.mask));
                chk("reply_cycle", 32'(cyc), 32'(e.due));
                chk("online_in_reply", 32'(disp_online), 32'h0);
            end
        end else if (rst && data_out != 32'h0) begin
            chk("idle_data", data_out, 32'h0);
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("reply_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    task automatic send(input logic is_stop, input logic [31:0] addr, input logic [31:0] data,
                        input int stall, input bit inject, input bit want_reply);
        exp_t        e;
        logic [31:0] res;
        int          t = 0;
        @(negedge clk);
        while (!disp_online && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!disp_online) chk("online_timeout", 32'(disp_online), 32'h1);
        predict(is_stop, addr, res);
        e.msg  = is_stop ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
        e.data = res;
        e.mask = m_valid;
        e.due  = cyc + 2 + stall;
        if (want_reply) sb.push_back(e);
        cpu_msg_pulse = 1'b1;
        cpu_msg_in    = is_stop ? CPU_R_STOP_THRD : CPU_R_FORK_THRD;
        addr_in       = addr;
        data_in       = data;
        @(negedge clk);
        chk("online_in_lookup", 32'(disp_online), 32'h0);
        if (inject) begin
            cpu_msg_in = CPU_R_FORK_THRD;
            addr_in    = 32'hE00;
            data_in    = 32'h1E0;
            @(negedge clk);
        end
        cpu_msg_pulse = 1'b0;
        if (stall > 0) begin
            clk_oe = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_no_reply", 32'(cpu_msg_out), 32'h0);
            end
            clk_oe = 1'b1;
        end
        if (want_reply) drain();
    endtask

    task automatic check_stats(input int exp_fail);
`ifdef THRD_DISP_STATS_EN
        chk("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        chk("active_cnt", 32'(active_cnt), 32'($countones(m_valid)));
`else
        chk("model_fail_track", 32'(m_fail), 32'(exp_fail));
`endif
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_msg",    32'(cpu_msg_out), 32'h0);
        chk("rst_data",   data_out, 32'h0);
        chk("rst_online", 32'(disp_online), 32'h0);
        chk("rst_mask",   32'(active_mask), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("online_held_in_rst", 32'(disp_online), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("online_after_rst", 32'(disp_online), 32'h1);

        send(1'b0, 32'h100, 32'h140, 0, 1'b0, 1'b1);
        chk("mask_first_fork", 32'(active_mask), 32'h01);
        send(1'b0, 32'h100, 32'h180, 0, 1'b0, 1'b1);
        chk("mask_dup_fork", 32'(active_mask), 32'h01);
        for (int i = 1; i < 8; i++) send(1'b0, 32'(32'h100 * (i + 1)), 32'(i), 0, 1'b0, 1'b1);
        chk("mask_full", 32'(active_mask), 32'hFF);
        send(1'b0, 32'h900, 32'h940, 0, 1'b0, 1'b1);
        check_stats(2);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mask_cleared", 32'(active_mask), 32'h0);
        m_valid = '0;
        m_fail  = 0;
        check_stats(0);
        @(negedge clk);
        rst = 1'b1;

        send(1'b0, 32'hA00, 32'hA40, 0, 1'b0, 1'b1);
        send(1'b0, 32'hB00, 32'hB40, 0, 1'b0, 1'b1);
        send(1'b0, 32'hC00, 32'hC40, 0, 1'b0, 1'b1);
        send(1'b1, 32'hB00, 32'h55,  0, 1'b0, 1'b1);
        chk("mask_after_stop", 32'(active_mask), 32'h05);
        send(1'b0, 32'hD00, 32'hD40, 0, 1'b0, 1'b1);
        chk("mask_reuse", 32'(active_mask), 32'h07);
        send(1'b1, 32'h999, 32'h0,   0, 1'b1, 1'b1);
        send(1'b0, 32'hE00, 32'h1E0, 5, 1'b0, 1'b1);
        chk("mask_after_stall", 32'(active_mask), 32'h0F);
        check_stats(1);

        send(1'b0, 32'hF00, 32'hF40, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reply_before_rst", 32'(cpu_msg_out), 32'(CPU_R_FORK_DONE));
        rst = 1'b0;
        #1;
        chk("rst_reply_msg",  32'(cpu_msg_out), 32'h0);
        chk("rst_reply_data", data_out, 32'h0);
        chk("rst_reply_mask", 32'(active_mask), 32'h0);
        m_valid = '0;
        m_fail  = 0;
        check_stats(0);
        @(negedge clk);
        rst = 1'b1;

        send(1'b0, 32'h100, 32'h140, 0, 1'b0, 1'b1);
        chk("mask_recover", 32'(active_mask), 32'h01);
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
